// File: rtl/mux_scan_ctrl_if.sv
// Handshake and mux-path bundle for the mux scan controller.
// The slave modport is the controller side. The master modport is the
// requester side, which also models the 16:1 mux that drives y_in.
interface mux_scan_ctrl_if;
  logic        start;
  logic        cont;
  logic        y_in;
  logic [3:0]  sel;
  logic        busy;
  logic        done;
  logic [15:0] data_out;

  modport master (
    output start, cont, y_in,
    input  sel, busy, done, data_out
  );

  modport slave (
    input  start, cont, y_in,
    output sel, busy, done, data_out
  );
endinterface

// File: rtl/mux_scan_ctrl.sv
// Scan sequencer for a 16:1 data mux.
// It walks the select codes 0..15 and holds each code for SETTLE+1 cycles.
// On the last cycle of each window it captures y_in into shadow bit [15-sel].
// When a scan completes, the whole snapshot is published to data_out in one
// step, together with a one-cycle done pulse.
module mux_scan_ctrl #(
  parameter int unsigned SETTLE = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  mux_scan_ctrl_if.slave  bus
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } state_t;

  localparam logic [3:0] LP_SETTLE = 4'(SETTLE);

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic [3:0]  r_sel;
  logic [15:0] r_shadow;
  logic [15:0] r_data;
  logic        r_busy;
  logic        r_done;

  logic        w_sample;
  logic        w_last;
  logic [15:0] w_shadow_next;

  assign w_sample = (r_cnt == LP_SETTLE);
  assign w_last   = (r_sel == 4'd15);

  // Shadow image with the current mux output merged in.
  // Select k routes d[15-k], so bit 15-sel receives y_in.
  always_comb begin
    w_shadow_next = r_shadow;
    w_shadow_next[4'd15 - r_sel] = bus.y_in;
  end

  // Scan state machine. All outputs are registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_cnt    <= 4'd0;
      r_sel    <= 4'd0;
      r_shadow <= 16'h0000;
      r_data   <= 16'h0000;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_sel  <= 4'd0;
          r_cnt  <= 4'd0;
          r_busy <= 1'b0;
          if (bus.start) begin
            r_state  <= ST_SCAN;
            r_busy   <= 1'b1;
            r_shadow <= 16'h0000;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_SCAN: begin
          if (w_sample) begin
            r_cnt <= 4'd0;
            if (w_last) begin
              // Final sample: publish the whole snapshot in one step.
              r_data   <= w_shadow_next;
              r_done   <= 1'b1;
              r_sel    <= 4'd0;
              r_shadow <= 16'h0000;
              if (bus.cont) begin
                r_state <= ST_SCAN;
                r_busy  <= 1'b1;
              end else begin
                r_state <= ST_IDLE;
                r_busy  <= 1'b0;
              end
            end else begin
              r_shadow <= w_shadow_next;
              r_sel    <= r_sel + 4'd1;
            end
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        default: begin
          r_state  <= ST_IDLE;
          r_cnt    <= 4'd0;
          r_sel    <= 4'd0;
          r_shadow <= 16'h0000;
          r_busy   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.sel      = r_sel;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.data_out = r_data;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Testbench for mux_scan_ctrl.
// Two instances are used: unit 0 has SETTLE=0 and unit 1 has SETTLE=1.
// Each unit is connected to a modelled 16:1 mux, y = d[15-sel].
module tb_mux_scan_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mux_scan_ctrl_if if0 ();
  mux_scan_ctrl_if if1 ();

  logic [15:0] d_q     [2];
  logic        start_q [2];
  logic        cont_q  [2];
  logic [15:0] prev_q  [2];

  logic [3:0]  sel_w   [2];
  logic        busy_w  [2];
  logic        done_w  [2];
  logic [15:0] data_w  [2];

  assign if0.start = start_q[0];
  assign if0.cont  = cont_q[0];
  assign if0.y_in  = d_q[0][4'd15 - if0.sel];
  assign if1.start = start_q[1];
  assign if1.cont  = cont_q[1];
  assign if1.y_in  = d_q[1][4'd15 - if1.sel];

  assign sel_w[0]  = if0.sel;
  assign busy_w[0] = if0.busy;
  assign done_w[0] = if0.done;
  assign data_w[0] = if0.data_out;
  assign sel_w[1]  = if1.sel;
  assign busy_w[1] = if1.busy;
  assign done_w[1] = if1.done;
  assign data_w[1] = if1.data_out;

  mux_scan_ctrl #(.SETTLE(0)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
  mux_scan_ctrl #(.SETTLE(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int          unit;
    logic [15:0] d;
    int          glitch;
    logic [15:0] exp_data;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string nm, input int u, input int cyc,
                     input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s unit%0d cyc%0d actual=%h required=%h", nm, u, cyc, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One scan window. If do_start is 0, the scan is the continuation of a
  // previous cont=1 scan. glitch>0 pulses start across edge T0+glitch.
  task automatic run_scan(input int u, input logic [15:0] d, input logic [15:0] exp,
                          input logic c, input bit do_start, input int glitch);
    int s1;
    int len;
    s1 = u + 1;
    len = 16 * s1;
    d_q[u] = d;
    cont_q[u] = c;
    if (do_start) begin
      start_q[u] = 1'b1;
      tick();
      start_q[u] = 1'b0;
      chk("busy_t0", u, 0, 16'(busy_w[u]), 16'h0001);
      chk("sel_t0", u, 0, 16'(sel_w[u]), 16'h0000);
    end
    for (int n = 1; n <= len; n++) begin
      tick();
      if (n < len) begin
        chk("sel", u, n, 16'(sel_w[u]), 16'(n / s1));
        chk("busy", u, n, 16'(busy_w[u]), 16'h0001);
        chk("done", u, n, 16'(done_w[u]), 16'h0000);
        chk("data_hold", u, n, data_w[u], prev_q[u]);
      end else begin
        chk("sel_end", u, n, 16'(sel_w[u]), 16'h0000);
        chk("busy_end", u, n, 16'(busy_w[u]), 16'(c));
        chk("done_end", u, n, 16'(done_w[u]), 16'h0001);
        chk("data_end", u, n, data_w[u], exp);
      end
      if (glitch > 0 && n == glitch - 1) start_q[u] = 1'b1;
      if (n == glitch) start_q[u] = 1'b0;
    end
    prev_q[u] = exp;
    if (!c) begin
      for (int k = 1; k <= 2; k++) begin
        tick();
        chk("idle_busy", u, len + k, 16'(busy_w[u]), 16'h0000);
        chk("idle_done", u, len + k, 16'(done_w[u]), 16'h0000);
        chk("idle_data", u, len + k, data_w[u], exp);
      end
    end
  endtask

  // Watchdog: any hang becomes a reported failure.
  initial begin
    #1000000;
    $display("FAIL watchdog timeout compared=%0d", n_cmp);
    $fatal(1, "timeout");
  end

  initial begin
    int cu;
    bit chain;
    int u;
    logic [15:0] d;
    logic c;
    int g;

    vecs[0] = '{unit: 1, d: 16'hA5C3, glitch: 0,  exp_data: 16'hA5C3};
    vecs[1] = '{unit: 0, d: 16'h8000, glitch: 0,  exp_data: 16'h8000};
    vecs[2] = '{unit: 0, d: 16'h0001, glitch: 0,  exp_data: 16'h0001};
    vecs[3] = '{unit: 1, d: 16'hBEEF, glitch: 10, exp_data: 16'hBEEF};
    vecs[4] = '{unit: 1, d: 16'h0000, glitch: 0,  exp_data: 16'h0000};
    vecs[5] = '{unit: 0, d: 16'h5A3C, glitch: 7,  exp_data: 16'h5A3C};

    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      d_q[i] = 16'h0000;
      start_q[i] = 1'b0;
      cont_q[i] = 1'b0;
      prev_q[i] = 16'h0000;
    end
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("rst_sel", i, 0, 16'(sel_w[i]), 16'h0000);
      chk("rst_busy", i, 0, 16'(busy_w[i]), 16'h0000);
      chk("rst_done", i, 0, 16'(done_w[i]), 16'h0000);
      chk("rst_data", i, 0, data_w[i], 16'h0000);
    end
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();

    // Table-driven single scans.
    for (int i = 0; i < 6; i++) begin
      run_scan(vecs[i].unit, vecs[i].d, vecs[i].exp_data, 1'b0, 1'b1, vecs[i].glitch);
    end

    // Continuous mode: two back-to-back scans with different data.
    run_scan(1, 16'h1234, 16'h1234, 1'b1, 1'b1, 0);
    run_scan(1, 16'hFEDC, 16'hFEDC, 1'b0, 1'b0, 0);

    // Randomized scans. The reference is that a completed snapshot equals d.
    chain = 1'b0;
    cu = 0;
    for (int i = 0; i < 16; i++) begin
      u = chain ? cu : int'($urandom_range(0, 1));
      d = 16'($urandom);
      c = (i < 15) ? 1'($urandom_range(0, 1)) : 1'b0;
      g = ($urandom_range(0, 1) == 1) ? int'($urandom_range(2, 16 * (u + 1) - 2)) : 0;
      run_scan(u, d, d, c, !chain, g);
      chain = c;
      cu = u;
    end

    // Mid-scan reset: everything clears asynchronously, then a clean rescan.
    run_scan(1, 16'h00FF, 16'h00FF, 1'b0, 1'b1, 0);
    d_q[1] = 16'h1111;
    start_q[1] = 1'b1;
    tick();
    start_q[1] = 1'b0;
    repeat (20) tick();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_sel", 1, 20, 16'(sel_w[1]), 16'h0000);
    chk("mid_rst_busy", 1, 20, 16'(busy_w[1]), 16'h0000);
    chk("mid_rst_done", 1, 20, 16'(done_w[1]), 16'h0000);
    chk("mid_rst_data", 1, 20, data_w[1], 16'h0000);
    chk("mid_rst_data_u0", 0, 20, data_w[0], 16'h0000);
    prev_q[0] = 16'h0000;
    prev_q[1] = 16'h0000;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    run_scan(1, 16'h5A5A, 16'h5A5A, 1'b0, 1'b1, 0);
    run_scan(0, 16'hC00C, 16'hC00C, 1'b0, 1'b1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
